// File: rtl/commit_checker_pkg.sv
// Shared types for the retirement checker: state encoding, field widths,
// the packed commit record and the record compare rule.
package commit_checker_pkg;

  localparam int unsigned PC_W   = 16;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DONE  = 2'd1,
    ERROR = 2'd2
  } chkState_t;

  // 70-bit commit record; 'reg' is a keyword so the write register is wreg
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic              rw;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] wdata;
    logic              mw;
    logic [PC_W-1:0]   addr;
    logic [DATA_W-1:0] mdata;
    logic              halt;
  } commitRec_t;

  // Flags always compared; payload fields only when the expected flag selects them
  function automatic logic recMatch(input commitRec_t e, input commitRec_t c);
    logic ok;
    ok = (e.pc == c.pc) && (e.rw == c.rw) && (e.mw == c.mw) && (e.halt == c.halt);
    if (e.rw) ok = ok && (e.wreg == c.wreg) && (e.wdata == c.wdata);
    if (e.mw) ok = ok && (e.addr == c.addr) && (e.mdata == c.mdata);
    return ok;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// Synchronous FIFO of expected commit records; pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module commit_fifo
  import commit_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  commitRec_t pushData,
  input  logic       pop,
  output commitRec_t headC,
  output logic       fullC,
  output logic       emptyC
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wrPtr;
  logic [AW:0] rdPtr;
  commitRec_t  mem [DEPTH];

  assign fullC  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign emptyC = (wrPtr == rdPtr);
  assign headC  = mem[rdPtr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !fullC) wrPtr <= wrPtr + (AW+1)'(1);
      if (pop && !emptyC) rdPtr <= rdPtr + (AW+1)'(1);
    end
  end

  // Storage is deliberately not reset; only the pointers define validity
  always_ff @(posedge clk) begin
    if (push && !fullC) mem[wrPtr[AW-1:0]] <= pushData;
  end

endmodule

// File: rtl/commit_checker.sv
// Compares each retired instruction against the oldest golden-trace record,
// counts matched commits and latches the first mismatch or underflow.
module commit_checker
  import commit_checker_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exp_valid,
  output logic              exp_ready,
  input  logic [PC_W-1:0]   exp_pc,
  input  logic              exp_rw,
  input  logic [REG_W-1:0]  exp_reg,
  input  logic [DATA_W-1:0] exp_wdata,
  input  logic              exp_mw,
  input  logic [PC_W-1:0]   exp_addr,
  input  logic [DATA_W-1:0] exp_mdata,
  input  logic              exp_halt,
  input  logic              cmt_valid,
  input  logic [PC_W-1:0]   cmt_pc,
  input  logic              cmt_rw,
  input  logic [REG_W-1:0]  cmt_reg,
  input  logic [DATA_W-1:0] cmt_wdata,
  input  logic              cmt_mw,
  input  logic [PC_W-1:0]   cmt_addr,
  input  logic [DATA_W-1:0] cmt_mdata,
  input  logic              cmt_halt,
  output logic [CNT_W-1:0]  inst_count,
  output logic              mismatch,
  output logic              underflow,
  output logic [CNT_W-1:0]  err_inum,
  output logic              done,
  output logic [1:0]        state
);

  commitRec_t expRec;
  commitRec_t cmtRec;
  commitRec_t headRec;
  logic       fifoFull;
  logic       fifoEmpty;
  logic       popC;
  logic       isMatchC;
  chkState_t  stateQ;

  assign expRec = '{pc: exp_pc, rw: exp_rw, wreg: exp_reg, wdata: exp_wdata,
                    mw: exp_mw, addr: exp_addr, mdata: exp_mdata, halt: exp_halt};
  assign cmtRec = '{pc: cmt_pc, rw: cmt_rw, wreg: cmt_reg, wdata: cmt_wdata,
                    mw: cmt_mw, addr: cmt_addr, mdata: cmt_mdata, halt: cmt_halt};

  assign exp_ready = !fifoFull;
  assign popC      = cmt_valid && (stateQ == RUN) && !fifoEmpty;
  assign isMatchC  = recMatch(headRec, cmtRec);
  assign state     = stateQ;

  commit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (exp_valid),
    .pushData (expRec),
    .pop      (popC),
    .headC    (headRec),
    .fullC    (fifoFull),
    .emptyC   (fifoEmpty)
  );

  // DONE and ERROR are terminal; only reset returns to RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ     <= RUN;
      inst_count <= '0;
      mismatch   <= 1'b0;
      underflow  <= 1'b0;
      err_inum   <= '0;
      done       <= 1'b0;
    end else begin
      case (stateQ)
        RUN: begin
          if (cmt_valid) begin
            if (fifoEmpty) begin
              underflow <= 1'b1;
              err_inum  <= inst_count;
              stateQ    <= ERROR;
            end else if (!isMatchC) begin
              mismatch  <= 1'b1;
              err_inum  <= inst_count;
              stateQ    <= ERROR;
            end else begin
              inst_count <= inst_count + CNT_W'(1);
              if (headRec.halt) begin
                done   <= 1'b1;
                stateQ <= DONE;
              end
            end
          end
        end
        default: stateQ <= stateQ;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_checker.sv
// Directed self-checking bench for commit_checker with DEPTH=8.
module tb_commit_checker;
  import commit_checker_pkg::*;

  logic        clk;
  logic        rst;
  logic        exp_valid;
  logic        exp_ready;
  logic [15:0] exp_pc;
  logic        exp_rw;
  logic [2:0]  exp_reg;
  logic [15:0] exp_wdata;
  logic        exp_mw;
  logic [15:0] exp_addr;
  logic [15:0] exp_mdata;
  logic        exp_halt;
  logic        cmt_valid;
  logic [15:0] cmt_pc;
  logic        cmt_rw;
  logic [2:0]  cmt_reg;
  logic [15:0] cmt_wdata;
  logic        cmt_mw;
  logic [15:0] cmt_addr;
  logic [15:0] cmt_mdata;
  logic        cmt_halt;
  logic [15:0] inst_count;
  logic        mismatch;
  logic        underflow;
  logic [15:0] err_inum;
  logic        done;
  logic [1:0]  state;

  int nChecks = 0;
  int nFails  = 0;

  commit_checker #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_pc(exp_pc), .exp_rw(exp_rw),
    .exp_reg(exp_reg), .exp_wdata(exp_wdata), .exp_mw(exp_mw), .exp_addr(exp_addr),
    .exp_mdata(exp_mdata), .exp_halt(exp_halt),
    .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_rw(cmt_rw), .cmt_reg(cmt_reg),
    .cmt_wdata(cmt_wdata), .cmt_mw(cmt_mw), .cmt_addr(cmt_addr), .cmt_mdata(cmt_mdata),
    .cmt_halt(cmt_halt),
    .inst_count(inst_count), .mismatch(mismatch), .underflow(underflow),
    .err_inum(err_inum), .done(done), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] want);
    nChecks++;
    if (got !== want) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic commitRec_t mkRec(input logic [15:0] pc, input logic rw, input logic [2:0] r,
                                       input logic [15:0] wd, input logic mw, input logic [15:0] ad,
                                       input logic [15:0] md, input logic halt);
    commitRec_t x;
    x.pc = pc; x.rw = rw; x.wreg = r; x.wdata = wd;
    x.mw = mw; x.addr = ad; x.mdata = md; x.halt = halt;
    return x;
  endfunction

  task automatic driveExp(input logic v, input commitRec_t r);
    exp_valid = v; exp_pc = r.pc; exp_rw = r.rw; exp_reg = r.wreg; exp_wdata = r.wdata;
    exp_mw = r.mw; exp_addr = r.addr; exp_mdata = r.mdata; exp_halt = r.halt;
  endtask

  task automatic driveCmt(input logic v, input commitRec_t r);
    cmt_valid = v; cmt_pc = r.pc; cmt_rw = r.rw; cmt_reg = r.wreg; cmt_wdata = r.wdata;
    cmt_mw = r.mw; cmt_addr = r.addr; cmt_mdata = r.mdata; cmt_halt = r.halt;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges and check that it takes effect before the next edge
  task automatic doReset(input string tag);
    exp_valid = 1'b0;
    cmt_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkVal({tag, "_outs"}, {inst_count, mismatch, underflow, err_inum, done, state}, 64'd0);
    checkVal({tag, "_ready"}, 64'(exp_ready), 64'd1);
    cycle();
    rst = 1'b0;
  endtask

  commitRec_t rA, rB, rC, rN, c;
  commitRec_t d [5];
  commitRec_t e1, e2, e3, c1, c2, c3;
  int accepted;

  initial begin
    rst = 1'b1;
    driveExp(1'b0, '0);
    driveCmt(1'b0, '0);
    cycle();
    cycle();
    checkVal("rst_count", 64'(inst_count), 64'd0);
    checkVal("rst_state", 64'(state), 64'd0);
    checkVal("rst_flags", 64'({mismatch, underflow, done}), 64'd0);
    checkVal("rst_errinum", 64'(err_inum), 64'd0);
    checkVal("rst_ready", 64'(exp_ready), 64'd1);
    rst = 1'b0;

    // Matching stream: reg write, store, halt
    rA = mkRec(16'h0000, 1'b1, 3'd1, 16'h0005, 1'b0, 16'h0000, 16'h0000, 1'b0);
    rB = mkRec(16'h0002, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010, 16'h0005, 1'b0);
    rC = mkRec(16'h0004, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b1);
    driveExp(1'b1, rA); cycle();
    driveExp(1'b1, rB); cycle();
    driveExp(1'b1, rC); cycle();
    exp_valid = 1'b0;
    driveCmt(1'b1, rA); cycle();
    checkVal("match_cnt1", 64'(inst_count), 64'd1);
    driveCmt(1'b1, rB); cycle();
    checkVal("match_cnt2", 64'(inst_count), 64'd2);
    checkVal("match_state_run", 64'(state), 64'd0);
    driveCmt(1'b1, rC); cycle();
    checkVal("match_cnt3", 64'(inst_count), 64'd3);
    checkVal("match_done", 64'(done), 64'd1);
    checkVal("match_state", 64'(state), 64'd1);
    checkVal("match_mismatch", 64'(mismatch), 64'd0);
    cycle();
    checkVal("done_ignore_cnt", 64'(inst_count), 64'd3);
    checkVal("done_no_underflow", 64'(underflow), 64'd0);
    checkVal("done_state", 64'(state), 64'd1);
    doReset("r1");

    // Data mismatch on the 5th commit, with push and pop overlapping
    for (int i = 0; i < 4; i++)
      d[i] = mkRec(16'(2 * i), 1'b1, 3'd1, 16'(i + 1), 1'b0, 16'h0000, 16'h0000, 1'b0);
    d[4] = mkRec(16'h0008, 1'b1, 3'd2, 16'h1234, 1'b0, 16'h0000, 16'h0000, 1'b0);
    driveExp(1'b1, d[0]); cycle();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) driveExp(1'b1, d[i + 1]);
      else exp_valid = 1'b0;
      c = d[i];
      if (i == 4) c.wdata = 16'h1235;
      driveCmt(1'b1, c);
      cycle();
    end
    checkVal("mm_flag", 64'(mismatch), 64'd1);
    checkVal("mm_errinum", 64'(err_inum), 64'd4);
    checkVal("mm_state", 64'(state), 64'd2);
    checkVal("mm_cnt", 64'(inst_count), 64'd4);
    driveCmt(1'b1, d[0]); cycle();
    cycle();
    checkVal("mm_hold_cnt", 64'(inst_count), 64'd4);
    checkVal("mm_no_underflow", 64'(underflow), 64'd0);
    doReset("r2");

    // Underflow with a same-cycle push; the pushed record must stay queued
    driveExp(1'b1, rA);
    driveCmt(1'b1, rA);
    cycle();
    cmt_valid = 1'b0;
    exp_valid = 1'b0;
    checkVal("uf_flag", 64'(underflow), 64'd1);
    checkVal("uf_state", 64'(state), 64'd2);
    checkVal("uf_errinum", 64'(err_inum), 64'd0);
    checkVal("uf_mismatch", 64'(mismatch), 64'd0);
    checkVal("uf_cnt", 64'(inst_count), 64'd0);
    exp_valid = 1'b1;
    for (int i = 0; i < 7; i++) cycle();
    exp_valid = 1'b0;
    checkVal("uf_kept_full", 64'(exp_ready), 64'd0);
    doReset("r3");

    // Don't-care fields, a load, then a store-with-update whose address differs
    e1 = mkRec(16'h0006, 1'b0, 3'd5, 16'hAAAA, 1'b0, 16'h1111, 16'h2222, 1'b0);
    c1 = mkRec(16'h0006, 1'b0, 3'd2, 16'h5555, 1'b0, 16'h9999, 16'h7777, 1'b0);
    e2 = mkRec(16'h0008, 1'b1, 3'd3, 16'h00FF, 1'b0, 16'h4444, 16'h0000, 1'b0);
    c2 = mkRec(16'h0008, 1'b1, 3'd3, 16'h00FF, 1'b0, 16'hBEEF, 16'hCAFE, 1'b0);
    e3 = mkRec(16'h000A, 1'b1, 3'd4, 16'h0101, 1'b1, 16'h0020, 16'h0033, 1'b0);
    c3 = mkRec(16'h000A, 1'b1, 3'd4, 16'h0101, 1'b1, 16'h0021, 16'h0033, 1'b0);
    driveExp(1'b1, e1); cycle();
    driveExp(1'b1, e2); cycle();
    driveExp(1'b1, e3); cycle();
    exp_valid = 1'b0;
    driveCmt(1'b1, c1); cycle();
    checkVal("dc_cnt", 64'(inst_count), 64'd1);
    checkVal("dc_mismatch", 64'(mismatch), 64'd0);
    driveCmt(1'b1, c2); cycle();
    checkVal("load_cnt", 64'(inst_count), 64'd2);
    driveCmt(1'b1, c3); cycle();
    cmt_valid = 1'b0;
    checkVal("stu_mismatch", 64'(mismatch), 64'd1);
    checkVal("stu_errinum", 64'(err_inum), 64'd2);
    checkVal("stu_state", 64'(state), 64'd2);
    doReset("r4");

    // Full FIFO with exp_valid held high throughout
    accepted = 0;
    driveExp(1'b1, mkRec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0));
    for (int i = 0; i < 8; i++) begin
      exp_pc = 16'(2 * i);
      if (exp_ready) accepted++;
      cycle();
    end
    checkVal("full_ready0", 64'(exp_ready), 64'd0);
    exp_pc = 16'h0010;
    if (exp_ready) accepted++;
    driveCmt(1'b1, mkRec(16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0));
    cycle();
    cmt_valid = 1'b0;
    checkVal("full_ready1", 64'(exp_ready), 64'd1);
    checkVal("full_cnt", 64'(inst_count), 64'd1);
    for (int i = 0; i < 3; i++) begin
      if (exp_ready) accepted++;
      cycle();
    end
    exp_valid = 1'b0;
    checkVal("full_ready_again", 64'(exp_ready), 64'd0);
    checkVal("full_accepted", 64'(accepted), 64'd9);
    doReset("r5");

    // Reset mid-run after two matches, then a fresh stream counts from zero
    driveExp(1'b1, rA); cycle();
    driveExp(1'b1, rB); cycle();
    driveExp(1'b1, rC); cycle();
    exp_valid = 1'b0;
    driveCmt(1'b1, rA); cycle();
    driveCmt(1'b1, rB); cycle();
    checkVal("mid_cnt2", 64'(inst_count), 64'd2);
    doReset("mid");
    rN = mkRec(16'h0100, 1'b1, 3'd7, 16'h0042, 1'b0, 16'h0000, 16'h0000, 1'b1);
    driveExp(1'b1, rN); cycle();
    exp_valid = 1'b0;
    driveCmt(1'b1, rN); cycle();
    cmt_valid = 1'b0;
    checkVal("mid_new_cnt", 64'(inst_count), 64'd1);
    checkVal("mid_new_done", 64'(done), 64'd1);
    checkVal("mid_new_mismatch", 64'(mismatch), 64'd0);
    checkVal("mid_new_state", 64'(state), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
